// File: rtl/log_mac_accum.sv
// ---------------------------------------------------------------------------
// LogMacAccum: streaming dot-product engine built around a logarithmic
// (Mitchell) multiplier. Each vector holds TAPS operand pairs.
// The pipeline has two stages:
//   1. The product is registered into r_prod.
//   2. r_prod is accumulated into a guard-bit accumulator.
// The result is presented with a valid/ready handshake and is held until
// the consumer takes it.
//
// Parameters
//   WIDTH - signed operand / product / result width
//   QP    - fractional bits of operands, product and result (1.0 = 2**QP)
//   TAPS  - operand pairs per dot product (2..64)
//
// Ports
//   clk       in   single clock, rising edge
//   rst       in   synchronous active-high reset
//   in_valid  in   operand pair present
//   in_ready  out  block accepts a pair this cycle
//   in1, in2  in   signed operands, QP fractional bits
//   out_valid out  dot-product result present
//   out_ready in   consumer takes result
//   acc_out   out  signed dot product, QP fractional bits
//   sat_flag  out  acc_out was clipped (qualified by out_valid)
//
// Build option
//   LOG_MAC_SAT_EN - when defined, the result is clipped to the WIDTH-bit
//                    signed range and sat_flag reports clipping. When
//                    undefined, the low WIDTH accumulator bits are output
//                    (wrap) and sat_flag is 0.
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// log_multiplier: combinational Mitchell approximate signed multiplier.
// Operand A has QP1 fractional bits and operand B has QP2; the result has
// QPO fractional bits. The result is exact whenever either magnitude is a
// power of two. Out-of-range products are clipped to the WIDTH-bit signed
// range. A zero operand gives exactly zero.
//
// Ports
//   i_a, i_b  in   signed operands
//   o_p       out  signed approximate product
// ---------------------------------------------------------------------------
module log_multiplier #(
  parameter int WIDTH = 16,
  parameter int QP1   = 12,
  parameter int QP2   = 12,
  parameter int QPO   = QP1
) (
  input  logic signed [WIDTH-1:0] i_a,
  input  logic signed [WIDTH-1:0] i_b,
  output logic signed [WIDTH-1:0] o_p
);

  localparam int KW   = $clog2(WIDTH) + 1;
  localparam int EW   = KW + 1;
  localparam int PW   = 3 * WIDTH;
  // Mantissa carries WIDTH-1 fraction bits, then rescale QP1+QP2 -> QPO.
  localparam int DROP = WIDTH - 1 + QP1 + QP2 - QPO;

  // Position of the most significant set bit (0 when v == 0).
  function automatic logic [KW-1:0] leadOne(input logic [WIDTH-1:0] v);
    leadOne = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (v[i]) leadOne = KW'(i);
    end
  endfunction

  logic             w_signA, w_signB, w_neg;
  logic [WIDTH-1:0] w_magA, w_magB;
  logic [KW-1:0]    w_kA, w_kB;
  logic [WIDTH-2:0] w_mA, w_mB;
  logic [WIDTH-1:0] w_mSum;
  logic [WIDTH-1:0] w_mant;
  logic [EW-1:0]    w_exp;
  logic [PW-1:0]    w_wide, w_mag, w_limit;
  logic [WIDTH-1:0] w_magSat, w_signed;

  assign w_signA = i_a[WIDTH-1];
  assign w_signB = i_b[WIDTH-1];
  assign w_neg   = w_signA ^ w_signB;
  // Unsigned magnitudes; the most negative value maps to 2**(WIDTH-1).
  assign w_magA  = w_signA ? (~i_a + 1'b1) : i_a;
  assign w_magB  = w_signB ? (~i_b + 1'b1) : i_b;

  // log2(m) ~= k + f, where f is the bits below the leading one,
  // left-aligned.
  assign w_kA = leadOne(w_magA);
  assign w_kB = leadOne(w_magB);
  assign w_mA = (WIDTH-1)'(w_magA << (KW'(WIDTH-1) - w_kA));
  assign w_mB = (WIDTH-1)'(w_magB << (KW'(WIDTH-1) - w_kB));

  // Antilog: without carry the value is 2^(kA+kB)*(1+fA+fB). With carry it
  // is 2^(kA+kB+1)*(fA+fB). Both cases share the mantissa {1, sum[low]}.
  assign w_mSum = {1'b0, w_mA} + {1'b0, w_mB};
  assign w_mant = {1'b1, w_mSum[WIDTH-2:0]};
  assign w_exp  = EW'(w_kA) + EW'(w_kB) + EW'(w_mSum[WIDTH-1]);
  assign w_wide = PW'(w_mant) << w_exp;
  assign w_mag  = w_wide >> DROP;

  // Negative results may reach 2**(WIDTH-1); positive results stop one
  // below that.
  assign w_limit  = w_neg ? PW'({1'b1, {(WIDTH-1){1'b0}}})
                          : PW'({1'b0, {(WIDTH-1){1'b1}}});
  assign w_magSat = (w_mag > w_limit) ? w_limit[WIDTH-1:0] : w_mag[WIDTH-1:0];
  assign w_signed = w_neg ? (~w_magSat + 1'b1) : w_magSat;

  assign o_p = ((w_magA == '0) || (w_magB == '0)) ? '0 : w_signed;

endmodule

module log_mac_accum #(
  parameter int WIDTH = 16,
  parameter int QP    = 12,
  parameter int TAPS  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] in1,
  input  logic signed [WIDTH-1:0] in2,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] acc_out,
  output logic                    sat_flag
);

  localparam int CW = $clog2(TAPS);
  localparam int AW = WIDTH + $clog2(TAPS);

  typedef enum logic [1:0] {ACCUM, DRAIN, HOLD} stateT;

  stateT                   r_state;
  logic [CW-1:0]           r_count;
  logic                    r_inReady;
  logic                    r_outValid;
  logic signed [WIDTH-1:0] r_accOut;
  logic                    r_satFlag;
  logic                    r_prodValid;
  logic                    r_prodFirst;
  logic signed [WIDTH-1:0] r_prod;
  logic signed [AW-1:0]    r_acc;

  logic signed [WIDTH-1:0] w_prod;
  logic                    w_xfer;
  logic                    w_lastXfer;
  logic [AW-1:0]           w_prodExt;
  logic signed [WIDTH-1:0] w_accResult;
  logic                    w_accSat;

  log_multiplier #(
    .WIDTH (WIDTH),
    .QP1   (QP),
    .QP2   (QP),
    .QPO   (QP)
  ) u_mult (
    .i_a (in1),
    .i_b (in2),
    .o_p (w_prod)
  );

  // r_inReady is high only in ACCUM, so a transfer can only happen there.
  assign w_xfer     = in_valid && r_inReady;
  assign w_lastXfer = w_xfer && (r_count == CW'(TAPS - 1));
  assign w_prodExt  = {{(AW-WIDTH){r_prod[WIDTH-1]}}, r_prod};

`ifdef LOG_MAC_SAT_EN
  // In range only when every bit from the WIDTH-1 sign position up is equal.
  logic [AW-WIDTH:0] w_accHigh;
  logic              w_accClip;
  assign w_accHigh   = r_acc[AW-1:WIDTH-1];
  assign w_accClip   = !((&w_accHigh) || !(|w_accHigh));
  assign w_accResult = !w_accClip ? r_acc[WIDTH-1:0]
                     : (r_acc[AW-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                    : {1'b0, {(WIDTH-1){1'b1}}});
  assign w_accSat    = w_accClip;
`else
  assign w_accResult = r_acc[WIDTH-1:0];
  assign w_accSat    = 1'b0;
`endif

  // Datapath: stage 1 captures the product of each transfer. Stage 2 folds
  // it into the accumulator. The first product of a vector replaces the old
  // sum, so a bubble never clears a partial sum.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prodValid <= 1'b0;
      r_prodFirst <= 1'b0;
      r_prod      <= '0;
      r_acc       <= '0;
    end else begin
      r_prodValid <= w_xfer;
      r_prodFirst <= w_xfer && (r_count == '0);
      if (w_xfer) r_prod <= w_prod;
      if (r_prodValid) r_acc <= (r_prodFirst ? '0 : r_acc) + w_prodExt;
    end
  end

  // Control: count transfers in ACCUM. DRAIN waits until stage 1 is empty,
  // which means the last product is already in the accumulator. The result
  // is then latched and held in HOLD until the consumer takes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ACCUM;
      r_count    <= '0;
      r_inReady  <= 1'b1;
      r_outValid <= 1'b0;
      r_accOut   <= '0;
      r_satFlag  <= 1'b0;
    end else begin
      case (r_state)
        ACCUM: begin
          if (w_xfer) begin
            r_count <= w_lastXfer ? '0 : r_count + 1'b1;
          end
          if (w_lastXfer) begin
            r_state   <= DRAIN;
            r_inReady <= 1'b0;
          end
        end
        DRAIN: begin
          if (!r_prodValid) begin
            r_state    <= HOLD;
            r_outValid <= 1'b1;
            r_accOut   <= w_accResult;
            r_satFlag  <= w_accSat;
          end
        end
        HOLD: begin
          if (out_ready) begin
            r_state    <= ACCUM;
            r_outValid <= 1'b0;
            r_inReady  <= 1'b1;
          end
        end
        default: begin
          r_state    <= ACCUM;
          r_count    <= '0;
          r_inReady  <= 1'b1;
          r_outValid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_inReady;
  assign out_valid = r_outValid;
  assign acc_out   = r_accOut;
  assign sat_flag  = r_satFlag;

endmodule

// File: doc/log_mac_accum.md
LOG_MAC_ACCUM -- requirements
Module: log_mac_accum

Interface
REQ-001 SHALL have parameter WIDTH, default 16: signed operand, product and result width.
REQ-002 SHALL have parameter QP, default 12: fractional bits of both operands and of the product; 1.0 = 4096.
REQ-003 SHALL have parameter TAPS, default 8: operand pairs per dot product; legal range 2..64.
REQ-004 SHALL have port clk, input, 1: single clock, all state on rising edge.
REQ-005 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port in_valid, input, 1: operand pair present.
REQ-007 SHALL have port in_ready, output, 1: block accepts pair this cycle.
REQ-008 SHALL have port in1, input, WIDTH: signed operand A, QP fractional bits.
REQ-009 SHALL have port in2, input, WIDTH: signed operand B, QP fractional bits.
REQ-010 SHALL have port out_valid, output, 1: dot-product result present.
REQ-011 SHALL have port out_ready, input, 1: consumer takes result.
REQ-012 SHALL have port acc_out, output, WIDTH: signed dot product, QP fractional bits.
REQ-013 SHALL have port sat_flag, output, 1: acc_out was clipped; qualified by out_valid.

Function
REQ-014 SHALL instantiate one log_multiplier (WIDTH, QP1=QP, QP2=QP) on in1/in2; no other multiplier.
REQ-015 SHALL accept a pair only on in_valid && in_ready (the transfer).
REQ-016 SHALL register each transferred product into prod_r with a valid bit (stage 1), one cycle after the transfer.
REQ-017 SHALL add sign-extended prod_r into an accumulator of WIDTH+clog2(TAPS) bits (stage 2), one cycle after stage 1; no internal wrap for any TAPS legal inputs.
REQ-018 SHALL clear the accumulator when the first pair of a new dot product is transferred, never by a mid-vector bubble.
REQ-019 SHALL count transfers 0..TAPS-1 and, on the TAPS-th transfer, wrap the counter to 0.
REQ-020 SHALL implement FSM states: ACCUM (in_ready=1), DRAIN (in_ready=0, pipeline emptying), HOLD (in_ready=0, out_valid=1).
REQ-021 SHALL move ACCUM->DRAIN on the TAPS-th transfer; DRAIN->HOLD when the last product is in the accumulator; HOLD->ACCUM on out_valid && out_ready.
REQ-022 SHALL assert out_valid exactly 2 cycles after the TAPS-th transfer (latency 2).
REQ-023 SHALL keep acc_out and sat_flag stable while out_valid=1 and out_ready=0.
REQ-024 SHALL raise in_ready in the cycle after the out_valid && out_ready handshake; no transfer in the handshake cycle itself.
REQ-025 SHALL ignore in_valid bubbles inside ACCUM: counter and accumulator hold.
REQ-026 SHALL ignore in1/in2/in_valid in DRAIN and HOLD.
REQ-027 SHALL produce 0 for any pair where either operand is 0, as log_multiplier does.

Reset
REQ-028 SHALL, on rst=1 at a clock edge, set state ACCUM, counter 0, accumulator 0, prod_r valid 0, out_valid 0, acc_out 0, sat_flag 0, in_ready 1 on the next cycle.
REQ-029 SHALL discard any partial dot product or held result when rst asserts mid-operation; no out_valid for it.

Configuration
REQ-030 SHALL, with LOG_MAC_SAT_EN defined, clip the accumulator to [-2^(WIDTH-1), 2^(WIDTH-1)-1] for acc_out and set sat_flag when clipping occurred.
REQ-031 SHALL, without LOG_MAC_SAT_EN, drive acc_out with the low WIDTH accumulator bits (two's-complement wrap) and tie sat_flag to 0.

Verification
REQ-032 SHALL cover: 8 pairs (2048, 4096), in_valid held high -> out_valid 2 cycles after 8th transfer, acc_out=16384, sat_flag=0.
REQ-033 SHALL cover: 8 pairs (4096, 4096) -> with macro acc_out=32767, sat_flag=1; without, acc_out=-32768, sat_flag=0.
REQ-034 SHALL cover: pairs alternating (-4096, 4096)/(4096, 4096), 8 total -> acc_out=0; also all pairs with in1=0 -> acc_out=0.
REQ-035 SHALL cover: in_valid toggling 1/0 each cycle plus out_ready=0 for 5 cycles -> same result as gap-free, acc_out stable, in_ready=0 until handshake.
REQ-036 SHALL cover: rst pulsed after 4 transfers, then 8 pairs (2048, 4096) -> single out_valid, acc_out=16384.
